dec_unbinder_seq: RTL and testbench
===================================

Name: dec_unbinder_seq

Overview:
- Inverse of the encoder binder stage. Takes a stream of bound hypervectors, one per feature, and undoes the per-feature circular shift. Emits the recovered level hypervectors in feature order.
- Sits on the decode/reconstruction path, after the search/associative stage. Feeds level-index lookup.
- Encoder convention: bound[j] = level[(j - SHIFT) mod HV_DIM], i.e. rotate left by SHIFT.
- This block produces out[j] = in[(j + SHIFT) mod HV_DIM], i.e. rotate right by SHIFT.

Parameters:
- HV_DIM, 1024: hypervector width in bits.
- NUM_FEATURES, 10: bound vectors per frame.
- SHIFT_BASE, 0: index into the package SHIFTS table. Feature k uses SHIFTS[SHIFT_BASE + k].

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nrst  input  1  reset. Synchronous, active-high: 1 = reset.
- start_decoding  input  1  one-cycle pulse that opens a frame.
- in_valid  input  1  in_hv is valid.
- in_ready  output  1  block accepts in_hv this cycle.
- in_hv  input  HV_DIM  bound hypervector for the current feature.
- out_valid  output  1  out_hv is valid.
- out_ready  input  1  downstream accepts out_hv.
- out_hv  output  HV_DIM  unbound (level) hypervector.
- out_idx  output  $clog2(NUM_FEATURES)  feature index of out_hv.
- out_last  output  1  out_hv belongs to feature NUM_FEATURES-1.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (nrst=1 at a clock edge):
  - FSM goes to IDLE; feature counter goes to 0.
  - in_ready, out_valid, out_last, busy and done go to 0.
  - out_hv and out_idx go to 0.
  - Reset mid-frame discards all state, including any held output. No done pulse is produced.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: in_ready=0, busy=0. start_decoding=1 → RUN, counter=0.
  - RUN: busy=1. in_ready = !out_valid || out_ready (1-deep output register with pass-through on pop).
  - Accept = in_valid && in_ready. On accept, the output register loads:
    - out_hv = rotate-right(in_hv, SHIFTS[SHIFT_BASE+counter] mod HV_DIM)
    - out_idx = counter
    - out_last = (counter == NUM_FEATURES-1)
    - out_valid = 1
  - Counter increments on accept. Accept of the last feature → DRAIN.
  - DRAIN: in_ready=0. When out_valid && out_ready with out_last=1, the block pulses done for 1 cycle, clears out_valid and returns to IDLE. busy drops in the same cycle that done is high.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 vector/cycle while out_ready=1.
- Output hold: out_hv, out_idx and out_last hold stable while out_valid=1 and out_ready=0. out_valid clears on pop if there is no simultaneous accept.
- Simultaneous pop and accept in RUN: the register reloads; out_valid stays 1.
- start_decoding while busy=1: ignored, no effect on counter or data.
- start_decoding in the same cycle as the done pulse: ignored. A new frame needs start in IDLE.
- Shift rules:
  - SHIFT is reduced mod HV_DIM at elaboration.
  - SHIFT 0 and SHIFT HV_DIM both give pass-through.
  - The rotation is a per-feature constant selected by counter: a mux over NUM_FEATURES precomputed rotations, not a runtime barrel shifter.
- in_valid while in IDLE or DRAIN: not accepted, no state change.

Test Plan:
- Round trip: HV_DIM=16, NUM_FEATURES=10, out_ready=1. Feed enc_binder outputs of level 0x8001 for all 10 features → out_hv=0x8001 for each; out_idx 0..9; out_last only on idx 9; done pulses 1 cycle after the idx-9 pop.
- Single rotation: SHIFT=3, in_hv=0x0008 → out_hv=0x0001. SHIFT=0, in_hv=0xA5A5 → 0xA5A5.
- Backpressure: out_ready=0 for 5 cycles after the first accept → in_ready=0 while the register is full; out_hv/out_idx stable. On release, no vector is lost or duplicated; 10 outputs total.
- Bubbles: in_valid toggling 1,0,1,0 → out_idx increments only on accepts; done appears only after 10 accepts.
- Reset mid-frame: assert nrst after 4 accepts → next cycle out_valid=0, busy=0, no done. A new start produces idx 0..9 correctly.
- Spurious start: start_decoding during RUN at idx 5 → counter continues 6..9; exactly one done per frame.

Source files
------------

// File: rtl/dec_unbinder_seq.sv
// Unbinder: undoes the per-feature left rotation applied by the binder.
// Emits recovered level vectors in feature order through a 1-deep register.
package dec_unbinder_pkg;
  localparam int NUM_SHIFTS = 16;
  localparam int SHIFTS [NUM_SHIFTS] = '{
    0, 3, 16, 5, 1, 7, 9, 13,
    20, 31, 2, 4, 6, 8, 10, 12
  };
endpackage

module dec_unbinder_seq
  import dec_unbinder_pkg::*;
#(
  parameter int HV_DIM       = 1024,
  parameter int NUM_FEATURES = 10,
  parameter int SHIFT_BASE   = 0,
  localparam int IW =
    (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] in_hv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic [IW-1:0]     out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST = IW'(NUM_FEATURES - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic [HV_DIM-1:0] hv_q, hv_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic [HV_DIM-1:0] rot [NUM_FEATURES];
  logic              accept;
  logic              pop;

  // Fixed wiring per feature; the counter only selects among them.
  for (genvar k = 0; k < NUM_FEATURES; k++) begin : g_feat
    localparam int S = SHIFTS[SHIFT_BASE + k] % HV_DIM;
    if (S == 0) begin : g_pass
      assign rot[k] = in_hv;
    end else begin : g_rot
      assign rot[k] = {in_hv[S-1:0], in_hv[HV_DIM-1:S]};
    end
  end

  assign in_ready = (state_q == RUN) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign pop      = ov_q && out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    hv_d    = hv_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_decoding && !done_q) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (pop) ov_d = 1'b0;
        if (accept) begin
          ov_d   = 1'b1;
          hv_d   = rot[cnt_q];
          idx_d  = cnt_q;
          last_d = (cnt_q == LAST);
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_q) begin
          ov_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      hv_q    <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      hv_q    <= hv_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = ov_q;
  assign out_hv    = hv_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Directed bench for dec_unbinder_seq at HV_DIM=16, NUM_FEATURES=10.
// Feeds binder-style left-rotated vectors and expects the levels back.
module tb_dec_unbinder_seq;

  localparam int HV = 16;
  localparam int NF = 10;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start_decoding;
  logic          in_valid;
  logic          in_ready;
  logic [HV-1:0] in_hv;
  logic          out_valid;
  logic          out_ready;
  logic [HV-1:0] out_hv;
  logic [3:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int dones    = 0;
  int pops0;
  int dones0;

  // SHIFTS[0..9] of the package, reduced mod 16 by hand.
  int sh [NF] = '{0, 3, 0, 5, 1, 7, 9, 13, 4, 15};

  dec_unbinder_seq #(
    .HV_DIM(HV),
    .NUM_FEATURES(NF),
    .SHIFT_BASE(0)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start_decoding(start_decoding),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_hv(in_hv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hv(out_hv),
    .out_idx(out_idx),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!nrst) begin
      if (out_valid && out_ready) pops <= pops + 1;
      if (done) dones <= dones + 1;
    end
  end

  function automatic logic [HV-1:0] rotl(
    input logic [HV-1:0] x, input int s);
    if (s == 0) return x;
    return (x << s) | (x >> (HV - s));
  endfunction

  function automatic logic [HV-1:0] lev(input int k);
    return 16'h3C00 ^ (16'h0111 * k[15:0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    start_decoding = 1'b1;
    tick();
    start_decoding = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  initial begin
    nrst = 1'b1;
    start_decoding = 1'b0;
    in_valid = 1'b0;
    in_hv = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_hv", out_hv, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    nrst = 1'b0;
    tick();

    // Round trip of level 0x8001
    pops0 = pops;
    dones0 = dones;
    start_frame();
    in_valid = 1'b1;
    for (int k = 0; k < NF; k++) begin
      in_hv = rotl(16'h8001, sh[k]);
      tick();
      chk("rt_valid", out_valid, 1);
      chk("rt_hv", out_hv, 16'h8001);
      chk("rt_idx", out_idx, k);
      chk("rt_last", out_last, (k == NF - 1));
      chk("rt_done", done, 0);
    end
    in_valid = 1'b0;
    chk("rt_drain_in_ready", in_ready, 0);
    chk("rt_drain_busy", busy, 1);
    tick();
    chk("rt_done_pulse", done, 1);
    chk("rt_done_busy", busy, 0);
    chk("rt_done_valid", out_valid, 0);
    tick();
    chk("rt_done_clear", done, 0);
    chk("rt_pops", pops - pops0, NF);
    chk("rt_dones", dones - dones0, 1);

    // Single rotations, then backpressure
    pops0 = pops;
    dones0 = dones;
    start_frame();
    in_valid = 1'b1;
    in_hv = 16'hA5A5;
    tick();
    chk("rot0_hv", out_hv, 16'hA5A5);
    in_hv = 16'h0008;
    tick();
    chk("rot3_hv", out_hv, 16'h0001);
    in_hv = 16'h1234;
    tick();
    chk("rot16_hv", out_hv, 16'h1234);
    chk("rot16_idx", out_idx, 2);
    out_ready = 1'b0;
    in_hv = rotl(lev(3), sh[3]);
    #1;
    chk("bp_in_ready0", in_ready, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_hv", out_hv, 16'h1234);
      chk("bp_idx", out_idx, 2);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int k = 3; k < NF; k++) begin
      in_hv = rotl(lev(k), sh[k]);
      tick();
      chk("bp_rel_hv", out_hv, lev(k));
      chk("bp_rel_idx", out_idx, k);
    end
    in_valid = 1'b0;
    tick();
    chk("bp_done", done, 1);
    tick();
    chk("bp_pops", pops - pops0, NF);
    chk("bp_dones", dones - dones0, 1);

    // Bubbles on the input
    pops0 = pops;
    dones0 = dones;
    start_frame();
    for (int k = 0; k < NF; k++) begin
      in_valid = 1'b1;
      in_hv = rotl(16'hC3A5 ^ 16'(k), sh[k]);
      tick();
      chk("bub_idx", out_idx, k);
      chk("bub_hv", out_hv, 16'hC3A5 ^ 16'(k));
      chk("bub_valid", out_valid, 1);
      in_valid = 1'b0;
      tick();
      chk("bub_gap_valid", out_valid, 0);
      chk("bub_done", done, (k == NF - 1));
    end
    tick();
    chk("bub_pops", pops - pops0, NF);
    chk("bub_dones", dones - dones0, 1);

    // Reset mid-frame after 4 accepts
    dones0 = dones;
    start_frame();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_hv = rotl(lev(k), sh[k]);
      tick();
    end
    chk("mid_idx", out_idx, 3);
    nrst = 1'b1;
    tick();
    chk("mid_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_in_ready", in_ready, 0);
    nrst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("mid_no_done", done, 0);
    chk("mid_dones", dones - dones0, 0);

    // New frame with a spurious start at idx 5
    pops0 = pops;
    dones0 = dones;
    start_frame();
    in_valid = 1'b1;
    for (int k = 0; k < NF; k++) begin
      in_hv = rotl(lev(k), sh[k]);
      start_decoding = (k == 6);
      tick();
      chk("sp_idx", out_idx, k);
      chk("sp_hv", out_hv, lev(k));
    end
    start_decoding = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("sp_done", done, 1);
    start_decoding = 1'b1;
    tick();
    start_decoding = 1'b0;
    chk("sp_start_at_done", busy, 0);
    chk("sp_done_once", done, 0);
    in_valid = 1'b1;
    tick();
    chk("idle_no_accept", out_valid, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;
    chk("sp_pops", pops - pops0, NF);
    chk("sp_dones", dones - dones0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
